adc_reset_sequencer: RTL and testbench
======================================

ADC_RESET_SEQUENCER -- requirements
Module: adc_reset_sequencer

Interface
REQ-001 SHALL provide parameter NUM_ADC, default 2: number of AK5394A-class ADCs sequenced together (1..8).
REQ-002 SHALL provide parameter PWR_DELAY, default 13520896 (~1.1 s at 12.288 MHz): cycles of VREF settle after power-on reset.
REQ-003 SHALL provide parameter RST_WIDTH, default 4: cycles ADC_RSTN is held low (minimum 3).
REQ-004 SHALL provide parameter CAL_MIN, default 16: cycles after reset release before CAL is sampled.
REQ-005 SHALL provide parameter CAL_TIMEOUT, default 12288000: maximum CAL_WAIT cycles, counted from reset release.
REQ-006 SHALL provide the port ADC_MCLK  in  1  sole clock (12.288 MHz).
REQ-007 SHALL provide the port ADC_nReset  in  1  asynchronous active-low reset.
REQ-008 SHALL provide the port recal_req  in  1  asynchronous recalibrate request, acted on at its rising edge.
REQ-009 SHALL provide the port ADC_CAL  in  NUM_ADC  per-ADC CAL pin, high while that ADC calibrates; asynchronous.
REQ-010 SHALL provide the port ADC_RSTN  out  NUM_ADC  per-ADC reset pin, active low, registered.
REQ-011 SHALL provide the port ready  out  1  high only in state RUN.
REQ-012 SHALL provide the port cal_error  out  NUM_ADC  sticky per-ADC calibration timeout flag.
REQ-013 SHALL provide the port state  out  2  current FSM state, for debug.

Function
REQ-014 SHALL synchronise recal_req and ADC_CAL through 2-flop synchronisers before use; a recal edge is a synchronised 0->1 transition.
REQ-015 SHALL implement an FSM with states PWR_WAIT=0, RST=1, CAL_WAIT=2, RUN=3.
REQ-016 PWR_WAIT SHALL drive ADC_RSTN all-ones for exactly PWR_DELAY cycles, then enter RST; recal edges in this state SHALL be ignored.
REQ-017 RST SHALL drive ADC_RSTN all-zeros for exactly RST_WIDTH cycles and clear cal_error on entry, then enter CAL_WAIT.
REQ-018 A recal edge in RST SHALL restart the RST_WIDTH count.
REQ-019 CAL_WAIT SHALL drive ADC_RSTN all-ones; after CAL_MIN cycles it SHALL enter RUN on the first cycle in which all synchronised CAL bits are low.
REQ-020 If CAL_WAIT reaches CAL_TIMEOUT cycles, it SHALL set cal_error[i] for every ADC whose synchronised CAL is still high, then enter RUN.
REQ-021 A timeout SHALL take precedence over CAL-low detection when both occur in the same cycle, setting no error bits only if all CAL bits are low.
REQ-022 A recal edge in CAL_WAIT or RUN SHALL enter RST on the next cycle; the PWR_WAIT state SHALL never be re-entered except via ADC_nReset.
REQ-023 ADC_RSTN and ready SHALL be registered outputs that change one cycle after the corresponding state transition.
REQ-024 Counters SHALL be sized with $clog2 of the largest of PWR_DELAY and CAL_TIMEOUT, plus one bit, and SHALL NOT wrap; each SHALL be cleared on every state entry.

Reset
REQ-025 While ADC_nReset is low: state=PWR_WAIT, ADC_RSTN=0, ready=0, cal_error=0, counters=0, and synchronisers=0.
REQ-026 ADC_nReset assertion mid-sequence (any state) SHALL abort immediately, and the full PWR_WAIT sequence SHALL rerun after release.

Structure
REQ-027 Package adc_seq_pkg SHALL hold the state encoding and default parameter constants.
REQ-028 A sub-module sync2 (parametrised width, 2-flop, async reset to 0) SHALL be used for recal_req and ADC_CAL.

Verification (bench params NUM_ADC=2, PWR_DELAY=100, RST_WIDTH=4, CAL_MIN=8, CAL_TIMEOUT=50)
REQ-029 Release ADC_nReset with CAL=00 -> ADC_RSTN=11 for 100 cycles, 00 for 4 cycles, then 11; ready=1 9..10 cycles after release of ADC_RSTN.
REQ-030 CAL=11 for 20 cycles after ADC_RSTN rises -> ready rises 2 sync + 1 cycles after CAL falls; cal_error=00.
REQ-031 ADC_CAL[1] stuck high -> at CAL_WAIT cycle 50, enter RUN with cal_error=10 and ready=1; the next recal clears cal_error.
REQ-032 recal_req pulse in RUN -> ADC_RSTN=00 for 4 cycles, with no PWR_WAIT; a second recal in RST, 2 cycles in, extends the low time to 6 cycles.
REQ-033 ADC_nReset asserted mid CAL_WAIT -> ADC_RSTN=00 and ready=0 asynchronously; after release, 100 cycles of PWR_WAIT.
REQ-034 recal_req toggled during PWR_WAIT -> no effect; the PWR_WAIT length is exactly 100 cycles.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the AK5394A reset/calibration sequencer:
// state encoding, default timing constants and counter sizing.
package adc_seq_pkg;

    // Sequencer states; the numeric values are visible on the debug port.
    typedef enum logic [1:0] {
        PWR_WAIT = 2'd0,
        RST      = 2'd1,
        CAL_WAIT = 2'd2,
        RUN      = 2'd3
    } seqState_t;

    // Defaults assume a 12.288 MHz master clock.
    localparam int DEF_NUM_ADC     = 2;
    localparam int DEF_PWR_DELAY   = 13520896;  // ~1.1 s VREF settle
    localparam int DEF_RST_WIDTH   = 4;         // ADC needs at least 3
    localparam int DEF_CAL_MIN     = 16;
    localparam int DEF_CAL_TIMEOUT = 12288000;  // ~1 s

    // One spare bit above the longest interval so a saturating counter
    // can never alias back onto a terminal count.
    function automatic int cntWidth(input int pwrDelay, input int calTimeout);
        int biggest;
        biggest = (pwrDelay > calTimeout) ? pwrDelay : calTimeout;
        return $clog2(biggest) + 1;
    endfunction

endpackage

// File: rtl/adc_reset_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, cleared to zero
// while reset is held.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [WIDTH-1:0] asyncIn,
    output logic [WIDTH-1:0] syncOut
);

    logic [WIDTH-1:0] metaReg;
    logic [WIDTH-1:0] syncReg;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            metaReg <= '0;
            syncReg <= '0;
        end else begin
            metaReg <= asyncIn;
            syncReg <= metaReg;
        end
    end

    assign syncOut = syncReg;

endmodule

// File: rtl/adc_reset_sequencer.sv
// Power-on / recalibration sequencer for a bank of AK5394A-class ADCs.
// Waits for VREF to settle, pulses the shared reset, then waits for every
// ADC to finish calibration (or times out and flags the stragglers).
module adc_reset_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_ADC     = DEF_NUM_ADC,
    parameter int PWR_DELAY   = DEF_PWR_DELAY,
    parameter int RST_WIDTH   = DEF_RST_WIDTH,
    parameter int CAL_MIN     = DEF_CAL_MIN,
    parameter int CAL_TIMEOUT = DEF_CAL_TIMEOUT
) (
    input  logic               ADC_MCLK,
    input  logic               ADC_nReset,
    input  logic               recal_req,
    input  logic [NUM_ADC-1:0] ADC_CAL,
    output logic [NUM_ADC-1:0] ADC_RSTN,
    output logic               ready,
    output logic [NUM_ADC-1:0] cal_error,
    output logic [1:0]         state
);

    localparam int CNT_W = cntWidth(PWR_DELAY, CAL_TIMEOUT);

    // Terminal counts: the counter holds the number of cycles already spent
    // in the current state, so "last cycle" is interval-1.
    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_DELAY - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_WIDTH - 1);
    localparam logic [CNT_W-1:0] CAL_LAST   = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAL_SETTLE = CNT_W'(CAL_MIN);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    seqState_t          stateReg;
    seqState_t          stateNext;
    logic [CNT_W-1:0]   cntReg;
    logic [CNT_W-1:0]   cntNext;
    logic               cntRestart;
    logic               errCapture;
    logic               errClear;
    logic [NUM_ADC-1:0] calErrorReg;
    logic [NUM_ADC-1:0] calErrorNext;
    logic [NUM_ADC-1:0] rstnReg;
    logic               readyReg;
    logic               recalSync;
    logic               recalPrev;
    logic               recalEdge;
    logic [NUM_ADC-1:0] calSync;

    sync2 #(.WIDTH(1)) recalSyncInst (
        .clk     (ADC_MCLK),
        .nReset  (ADC_nReset),
        .asyncIn (recal_req),
        .syncOut (recalSync)
    );

    sync2 #(.WIDTH(NUM_ADC)) calSyncInst (
        .clk     (ADC_MCLK),
        .nReset  (ADC_nReset),
        .asyncIn (ADC_CAL),
        .syncOut (calSync)
    );

    // Delayed copy of the synchronised request for rising-edge detection.
    always_ff @(posedge ADC_MCLK or negedge ADC_nReset) begin
        if (!ADC_nReset) begin
            recalPrev <= 1'b0;
        end else begin
            recalPrev <= recalSync;
        end
    end

    assign recalEdge = recalSync & ~recalPrev;

    // Next-state decode; recal outranks the timeout, timeout outranks CAL-low.
    always_comb begin
        stateNext  = stateReg;
        cntRestart = 1'b0;
        errCapture = 1'b0;
        case (stateReg)
            PWR_WAIT: begin
                // Recal requests are deliberately ignored until VREF is up.
                if (cntReg == PWR_LAST) begin
                    stateNext = RST;
                end
            end
            RST: begin
                if (recalEdge) begin
                    cntRestart = 1'b1;
                end else if (cntReg == RST_LAST) begin
                    stateNext = CAL_WAIT;
                end
            end
            CAL_WAIT: begin
                if (recalEdge) begin
                    stateNext = RST;
                end else if (cntReg == CAL_LAST) begin
                    stateNext  = RUN;
                    errCapture = 1'b1;
                end else if ((cntReg >= CAL_SETTLE) && (calSync == '0)) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (recalEdge) begin
                    stateNext = RST;
                end
            end
            default: begin
                stateNext = PWR_WAIT;
            end
        endcase
    end

    // Errors from a previous calibration are dropped as the new reset begins.
    assign errClear = (stateNext == RST) && (stateReg != RST);

    // Per-ADC sticky timeout flags: latch whichever CAL pins are still high.
    for (genvar gi = 0; gi < NUM_ADC; gi++) begin : gCalErr
        assign calErrorNext[gi] = errClear ? 1'b0
                                : (calErrorReg[gi] | (errCapture & calSync[gi]));
    end

    // Cycle counter: zero on every state entry or RST restart, saturates.
    always_comb begin
        cntNext = cntReg;
        if ((stateNext != stateReg) || cntRestart) begin
            cntNext = '0;
        end else if (cntReg != CNT_MAX) begin
            cntNext = cntReg + 1'b1;
        end
    end

    // State, counter and error flag registers.
    always_ff @(posedge ADC_MCLK or negedge ADC_nReset) begin
        if (!ADC_nReset) begin
            stateReg    <= PWR_WAIT;
            cntReg      <= '0;
            calErrorReg <= '0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            calErrorReg <= calErrorNext;
        end
    end

    // Pin outputs follow the current state one cycle later, glitch-free.
    always_ff @(posedge ADC_MCLK or negedge ADC_nReset) begin
        if (!ADC_nReset) begin
            rstnReg  <= '0;
            readyReg <= 1'b0;
        end else begin
            rstnReg  <= (stateReg == RST) ? '0 : '1;
            readyReg <= (stateReg == RUN);
        end
    end

    assign ADC_RSTN  = rstnReg;
    assign ready     = readyReg;
    assign cal_error = calErrorReg;
    assign state     = stateReg;

endmodule

// File: tb/tb_adc_reset_sequencer.sv
// Directed bench for adc_reset_sequencer with a cycle model checked on
// every falling edge, plus hand-computed interval checks.
module tb_adc_reset_sequencer;

    localparam int NA = 2;
    localparam int PD = 100;
    localparam int RW = 4;
    localparam int CM = 8;
    localparam int CT = 50;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          recal = 1'b0;
    logic [NA-1:0] cal = '0;
    logic [NA-1:0] rstn;
    logic          rdy;
    logic [NA-1:0] err;
    logic [1:0]    st;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    adc_reset_sequencer #(
        .NUM_ADC     (NA),
        .PWR_DELAY   (PD),
        .RST_WIDTH   (RW),
        .CAL_MIN     (CM),
        .CAL_TIMEOUT (CT)
    ) dut (
        .ADC_MCLK   (clk),
        .ADC_nReset (nReset),
        .recal_req  (recal),
        .ADC_CAL    (cal),
        .ADC_RSTN   (rstn),
        .ready      (rdy),
        .cal_error  (err),
        .state      (st)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase + remaining/elapsed time, inputs seen
    // two clocks late, pin outputs reflect the previous cycle's phase.
    // Phases: 0 power wait, 1 reset pulse, 2 calibration wait, 3 run.
    // ------------------------------------------------------------------
    int            mPhase;
    int            mLeft;
    int            mIn;
    logic [NA-1:0] mRstn;
    logic          mReady;
    logic [NA-1:0] mErr;
    logic          rm1, rm2, rm3;
    logic [NA-1:0] cm1, cm2;

    task automatic modelReset();
        mPhase = 0; mLeft = PD; mIn = 0;
        mRstn = '0; mReady = 1'b0; mErr = '0;
        rm1 = 1'b0; rm2 = 1'b0; rm3 = 1'b0;
        cm1 = '0; cm2 = '0;
    endtask

    task automatic enterReset();
        mPhase = 1; mLeft = RW; mErr = '0;
    endtask

    task automatic modelStep();
        logic          recalSeen;
        logic [NA-1:0] calSeen;
        logic [NA-1:0] nRstn;
        logic          nReady;
        recalSeen = rm2 & ~rm3;
        calSeen   = cm2;
        nRstn     = (mPhase == 1) ? '0 : '1;
        nReady    = (mPhase == 3);
        case (mPhase)
            0: if (mLeft == 1) enterReset(); else mLeft--;
            1: begin
                if (recalSeen) enterReset();
                else if (mLeft == 1) begin mPhase = 2; mIn = 1; end
                else mLeft--;
            end
            2: begin
                if (recalSeen) enterReset();
                else if (mIn == CT) begin mErr = mErr | calSeen; mPhase = 3; end
                else if (mIn > CM && calSeen == '0) mPhase = 3;
                else mIn++;
            end
            default: if (recalSeen) enterReset();
        endcase
        rm3 = rm2; rm2 = rm1; rm1 = recal;
        cm2 = cm1; cm1 = cal;
        mRstn = nRstn; mReady = nReady;
    endtask

    // Compare process: every falling edge, DUT against model.
    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            if (!nReset) modelReset();
            chk("m_rstn",  32'(rstn), 32'(mRstn));
            chk("m_ready", 32'(rdy),  32'(mReady));
            chk("m_err",   32'(err),  32'(mErr));
            chk("m_state", 32'(st),   32'(mPhase));
            if (nReset) modelStep();
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a falling edge; advances until ADC_RSTN equals v.
    task automatic waitRstn(input logic [NA-1:0] v, input string name);
        int n;
        n = 0;
        while (rstn !== v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (rstn !== v) begin
            total++;
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b (timed out)", name, $time, rstn, v);
        end
    endtask

    // Called at a falling edge; counts consecutive cycles with ADC_RSTN == v.
    task automatic runLen(input logic [NA-1:0] v, output int n);
        n = 0;
        while (rstn === v && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Called at a falling edge; counts cycles until ready is high.
    task automatic readyDelay(output int n);
        n = 0;
        while (rdy !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;

        // Reset held: all outputs at their reset values.
        repeat (3) tick();
        @(negedge clk);
        chk("reset_rstn",  32'(rstn), 32'h0);
        chk("reset_ready", 32'(rdy),  32'h0);
        chk("reset_err",   32'(err),  32'h0);
        chk("reset_state", 32'(st),   32'h0);
        $display("[%0t] reset held: ADC_RSTN=%b ready=%b state=%0d", $time, rstn, rdy, st);

        // Power-on sequence with CAL idle.
        tick(); nReset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        runLen(2'b11, n); chk("pwr_len", 32'(n), 32'd100);
        runLen(2'b00, n); chk("rst_len", 32'(n), 32'd4);
        readyDelay(n);
        chk("ready_9_10", 32'(n >= 9 && n <= 10), 32'h1);
        chk("poweron_err", 32'(err), 32'h0);
        $display("[%0t] power-on: ready %0d cycles after ADC_RSTN rise", $time, n);

        // Recal from RUN, then CAL held high for 20 cycles.
        tick(); recal = 1'b1;
        tick(); recal = 1'b0;
        @(negedge clk);
        waitRstn(2'b00, "recal1_low");
        runLen(2'b00, n); chk("recal_rst_len", 32'(n), 32'd4);
        tick(); cal = 2'b11;
        repeat (20) tick();
        cal = 2'b00;
        @(negedge clk);
        @(negedge clk);
        // First edge sampling CAL low is behind us; 2 sync stages + state,
        // then ready shows on the 3rd edge after that.
        readyDelay(n); chk("cal_fall_latency", 32'(n), 32'd3);
        chk("cal_ok_err", 32'(err), 32'h0);
        $display("[%0t] recal + CAL busy: ready %0d cycles after sampling CAL low", $time, n);

        // ADC 1 stuck calibrating: timeout at CAL_WAIT cycle 50.
        tick(); recal = 1'b1; cal = 2'b10;
        tick(); recal = 1'b0;
        @(negedge clk);
        waitRstn(2'b00, "recal2_low");
        runLen(2'b00, n);
        readyDelay(n); chk("timeout_latency", 32'(n), 32'd50);
        chk("timeout_err",   32'(err), 32'h2);
        chk("timeout_ready", 32'(rdy), 32'h1);
        $display("[%0t] CAL[1] stuck: timeout after %0d cycles, cal_error=%b", $time, n, err);

        // Next recal clears the sticky error.
        tick(); recal = 1'b1; cal = 2'b00;
        tick(); recal = 1'b0;
        @(negedge clk);
        waitRstn(2'b00, "recal3_low");
        chk("err_cleared", 32'(err), 32'h0);
        runLen(2'b00, n);
        readyDelay(n);
        $display("[%0t] recal cleared cal_error=%b", $time, err);

        // Recal, then a second one landing on the 2nd RST cycle.
        tick(); recal = 1'b1;
        tick(); recal = 1'b0;
        tick(); recal = 1'b1;
        tick(); recal = 1'b0;
        @(negedge clk);
        waitRstn(2'b00, "recal4_low");
        runLen(2'b00, n); chk("recal_extend_len", 32'(n), 32'd6);
        readyDelay(n); chk("ready_after_extend", 32'(rdy), 32'h1);
        $display("[%0t] double recal: ADC_RSTN low 6 cycles expected, ready=%b", $time, rdy);

        // Reset asserted in the middle of CAL_WAIT.
        tick(); recal = 1'b1; cal = 2'b11;
        tick(); recal = 1'b0;
        @(negedge clk);
        waitRstn(2'b00, "recal5_low");
        waitRstn(2'b11, "recal5_high");
        repeat (5) tick();
        chk("pre_abort_state", 32'(st), 32'h2);
        nReset = 1'b0;
        #1;
        chk("abort_rstn",  32'(rstn), 32'h0);
        chk("abort_ready", 32'(rdy),  32'h0);
        chk("abort_state", 32'(st),   32'h0);
        $display("[%0t] abort in CAL_WAIT: ADC_RSTN=%b state=%0d", $time, rstn, st);

        // Release with recal toggling throughout the power wait.
        repeat (3) tick();
        tick(); nReset = 1'b1; cal = 2'b00;
        fork
            begin
                repeat (30) begin
                    tick();
                    recal = ~recal;
                end
                recal = 1'b0;
            end
        join_none
        @(negedge clk);
        @(negedge clk);
        runLen(2'b11, n); chk("pwr_len_rerun", 32'(n), 32'd100);
        runLen(2'b00, n); chk("rst_len_rerun", 32'(n), 32'd4);
        readyDelay(n);
        chk("ready_rerun", 32'(n >= 9 && n <= 10), 32'h1);
        $display("[%0t] rerun with recal noise: power wait then ready after %0d", $time, n);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
